// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, port indices
// and the default memory geometry used by the processor top and data memory.
package dmem_arbiter_pkg;

   localparam int DMEM_ADDR_W = 8;
   localparam int DMEM_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic PORT0 = 1'b0;
   localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-requester round-robin picker: on a tie the port that did not win last
// time is chosen, otherwise the single requester wins.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant
);

   assign grant_valid = req0 | req1;
   assign grant       = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU (port 0) and debug-loader (port 1) accesses onto the single
// data-memory port: IDLE -> ACCESS -> RESP, one access every three cycles.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_W = DMEM_ADDR_W,
   parameter int DATA_W = DMEM_DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              p0_req,
   input  logic              p0_we,
   input  logic [ADDR_W-1:0] p0_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   state_t            r_state;
   logic              r_last_grant;
   logic              r_grant;
   logic              r_p0_ack;
   logic              r_p1_ack;
   logic [DATA_W-1:0] r_p0_rdata;
   logic [DATA_W-1:0] r_p1_rdata;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_mem_read;
   logic              r_mem_write;
   logic              r_busy;

   logic              w_grant_valid;
   logic              w_grant;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   rr_arb2 u_rr_arb2 (
      .req0        (p0_req),
      .req1        (p1_req),
      .last_grant  (r_last_grant),
      .grant_valid (w_grant_valid),
      .grant       (w_grant)
   );

   assign w_sel_we    = (w_grant == PORT1) ? p1_we    : p0_we;
   assign w_sel_addr  = (w_grant == PORT1) ? p1_addr  : p0_addr;
   assign w_sel_wdata = (w_grant == PORT1) ? p1_wdata : p0_wdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_last_grant <= PORT1;   // so port 0 wins the first tie
         r_grant      <= PORT0;
         r_p0_ack     <= 1'b0;
         r_p1_ack     <= 1'b0;
         r_p0_rdata   <= '0;
         r_p1_rdata   <= '0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_read   <= 1'b0;
         r_mem_write  <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_grant     <= w_grant;
                  r_mem_addr  <= w_sel_addr;
                  r_mem_wdata <= w_sel_wdata;
                  r_mem_write <= w_sel_we;
                  r_mem_read  <= ~w_sel_we;
                  r_busy      <= 1'b1;
                  r_state     <= ACCESS;
               end
            end
            ACCESS: begin
               // memory output is combinational, so it is valid at this closing edge
               if (r_mem_read) begin
                  if (r_grant == PORT1) r_p1_rdata <= mem_rdata;
                  else                  r_p0_rdata <= mem_rdata;
               end
               r_mem_addr   <= '0;
               r_mem_wdata  <= '0;
               r_mem_read   <= 1'b0;
               r_mem_write  <= 1'b0;
               r_p0_ack     <= (r_grant == PORT0);
               r_p1_ack     <= (r_grant == PORT1);
               r_last_grant <= r_grant;
               r_state      <= RESP;
            end
            RESP: begin
               r_p0_ack <= 1'b0;
               r_p1_ack <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

   assign p0_ack    = r_p0_ack;
   assign p1_ack    = r_p1_ack;
   assign p0_rdata  = r_p0_rdata;
   assign p1_rdata  = r_p1_rdata;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_read  = r_mem_read;
   assign mem_write = r_mem_write;
   assign busy      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed vector table, multi-cycle
// corner sequences, then randomized two-port traffic against a transaction model.
module tb_dmem_arbiter;

   logic       clk;
   logic       reset;
   logic       p0_req, p0_we, p1_req, p1_we;
   logic [7:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic       p0_ack, p1_ack;
   logic [7:0] p0_rdata, p1_rdata;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;
   logic       mem_read, mem_write;
   logic       busy;

   logic       preload;
   logic [7:0] mem_arr [256];
   logic [7:0] ref_mem [256];

   int n_vec  = 0;
   int n_miss = 0;
   int cyc;

   dmem_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_ack    (p0_ack),
      .p0_rdata  (p0_rdata),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_ack    (p1_ack),
      .p1_rdata  (p1_rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data memory stand-in: synchronous write, combinational read, mem[i]=i preload.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 256; i++) mem_arr[i] <= 8'(i);
      end else if (mem_write) begin
         mem_arr[mem_addr] <= mem_wdata;
      end
   end
   assign mem_rdata = mem_arr[mem_addr];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       port;
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_r0;
      logic [7:0] exp_r1;
   } vec_t;

   vec_t vecs [10];

   task automatic drive_port(input logic port, input logic req, input logic we,
                             input logic [7:0] addr, input logic [7:0] wdata);
      if (port == 1'b0) begin
         p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
      end else begin
         p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
      end
   endtask

   // One single-port transaction, started just after an edge with the DUT idle.
   task automatic apply(input vec_t v, input int idx);
      drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
      @(posedge clk); #1;
      check($sformatf("v%0d_access_busy", idx), busy, 1);
      check($sformatf("v%0d_access_mem_read", idx), mem_read, !v.we);
      check($sformatf("v%0d_access_mem_write", idx), mem_write, v.we);
      check($sformatf("v%0d_access_mem_addr", idx), mem_addr, v.addr);
      if (v.we) check($sformatf("v%0d_access_mem_wdata", idx), mem_wdata, v.wdata);
      check($sformatf("v%0d_access_no_ack", idx), {p0_ack, p1_ack}, 0);
      @(posedge clk); #1;
      check($sformatf("v%0d_p0_ack", idx), p0_ack, (v.port == 1'b0));
      check($sformatf("v%0d_p1_ack", idx), p1_ack, (v.port == 1'b1));
      check($sformatf("v%0d_resp_mem_lines", idx), {mem_read, mem_write}, 0);
      check($sformatf("v%0d_p0_rdata", idx), p0_rdata, v.exp_r0);
      check($sformatf("v%0d_p1_rdata", idx), p1_rdata, v.exp_r1);
      drive_port(v.port, 1'b0, 1'b0, 8'h00, 8'h00);
      @(posedge clk); #1;
      check($sformatf("v%0d_ack_cleared", idx), {p0_ack, p1_ack}, 0);
      check($sformatf("v%0d_idle_busy", idx), busy, 0);
      $display("vector %0d: port %0d %s addr %02h -> p0_rdata %02h p1_rdata %02h",
               idx, v.port, v.we ? "write" : "read", v.addr, p0_rdata, p1_rdata);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   // Transaction-level model state for the randomized phase.
   logic       rq    [2];
   logic       rwe   [2];
   logic [7:0] raddr [2];
   logic [7:0] rwd   [2];
   int         rstart[2];
   logic [7:0] last_rd [2];
   logic       ack_s [2];
   logic [7:0] rd_s  [2];
   int         last_ack_port;

   initial begin
      reset = 1'b1; preload = 1'b1;
      p0_req = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
      p1_req = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;

      vecs[0] = '{1'b0, 1'b0, 8'h05, 8'h00, 8'h05, 8'h00};
      vecs[1] = '{1'b1, 1'b1, 8'h10, 8'hA5, 8'h05, 8'h00};
      vecs[2] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5, 8'h00};
      vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5, 8'hA5};
      vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h3C, 8'hA5, 8'hA5};
      vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'hA5, 8'h3C};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h3C};
      vecs[7] = '{1'b1, 1'b0, 8'h80, 8'h00, 8'h00, 8'h80};
      vecs[8] = '{1'b0, 1'b1, 8'h00, 8'h5A, 8'h00, 8'h80};
      vecs[9] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h5A, 8'h80};

      repeat (2) @(posedge clk);
      #1;
      preload = 1'b0;
      check("reset_busy", busy, 0);
      check("reset_acks", {p0_ack, p1_ack}, 0);
      check("reset_rdata", {p0_rdata, p1_rdata}, 0);
      check("reset_mem_lines", {mem_read, mem_write}, 0);
      check("reset_mem_addr_wdata", {mem_addr, mem_wdata}, 0);
      reset = 1'b0;
      $display("reset: busy %0d acks %0d%0d", busy, p0_ack, p1_ack);

      for (int i = 0; i < 10; i++) apply(vecs[i], i);

      // Both ports request continuously: acks alternate p0,p1,... one per 3 cycles.
      do_reset();
      drive_port(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
      drive_port(1'b1, 1'b1, 1'b0, 8'h02, 8'h00);
      for (int i = 0; i < 18; i++) begin
         @(posedge clk); #1;
         check($sformatf("rr_c%0d_p0_ack", i), p0_ack, (i % 3 == 1) && ((i / 3) % 2 == 0));
         check($sformatf("rr_c%0d_p1_ack", i), p1_ack, (i % 3 == 1) && ((i / 3) % 2 == 1));
         if (p0_ack) check($sformatf("rr_c%0d_p0_rdata", i), p0_rdata, 8'h01);
         if (p1_ack) check($sformatf("rr_c%0d_p1_rdata", i), p1_rdata, 8'h02);
         $display("rr cycle %0d: p0_ack %0d p1_ack %0d", i, p0_ack, p1_ack);
      end
      drive_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      drive_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      @(posedge clk); #1;

      // Port 0 alone, back-to-back reads: not held off by its own last grant.
      drive_port(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
      for (int i = 0; i < 7; i++) begin
         @(posedge clk); #1;
         check($sformatf("b2b_c%0d_p0_ack", i), p0_ack, (i == 1) || (i == 4));
         check($sformatf("b2b_c%0d_p1_ack", i), p1_ack, 0);
         if (i == 1) begin
            check("b2b_first_rdata", p0_rdata, 8'h01);
            p0_addr = 8'h02;
         end
         if (i == 4) begin
            check("b2b_second_rdata", p0_rdata, 8'h02);
            p0_req = 1'b0;
         end
         $display("b2b cycle %0d: p0_ack %0d p0_rdata %02h", i, p0_ack, p0_rdata);
      end

      // Reset lands while a port 1 write is in ACCESS.
      drive_port(1'b1, 1'b1, 1'b1, 8'h20, 8'h77);
      @(posedge clk); #1;
      check("rst_mid_write_active", mem_write, 1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_mem_lines", {mem_read, mem_write}, 0);
      check("rst_mid_p1_ack", p1_ack, 0);
      check("rst_mid_rdata", {p0_rdata, p1_rdata}, 0);
      reset = 1'b0;
      drive_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check($sformatf("rst_after_c%0d_p1_ack", i), p1_ack, 0);
      end
      $display("reset mid-access: busy %0d mem_write %0d p1_ack %0d", busy, mem_write, p1_ack);

      // Randomized traffic on both ports against the transaction model.
      preload = 1'b1;
      reset = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i);
      for (int p = 0; p < 2; p++) begin
         rq[p] = 0; rwe[p] = 0; raddr[p] = 0; rwd[p] = 0; rstart[p] = 0; last_rd[p] = 0;
      end
      last_ack_port = 1;
      cyc = 0;
      for (int c = 0; c < 1000; c++) begin
         @(posedge clk); #1;
         cyc++;
         ack_s[0] = p0_ack;   ack_s[1] = p1_ack;
         rd_s[0]  = p0_rdata; rd_s[1]  = p1_rdata;
         check("rnd_mem_exclusive", mem_read && mem_write, 0);
         check("rnd_single_ack", ack_s[0] && ack_s[1], 0);
         if (mem_read || mem_write) begin
            check("rnd_mem_only_when_busy", busy, 1);
            check("rnd_mem_not_in_resp", ack_s[0] || ack_s[1], 0);
            check("rnd_mem_addr_from_request",
                  (rq[0] && rwe[0] == mem_write && raddr[0] == mem_addr) ||
                  (rq[1] && rwe[1] == mem_write && raddr[1] == mem_addr), 1);
         end
         for (int p = 0; p < 2; p++) begin
            if (ack_s[p]) begin
               check($sformatf("rnd_p%0d_ack_pending", p), rq[p], 1);
               check($sformatf("rnd_p%0d_rr_fair", p),
                     (last_ack_port == p) && rq[1-p] && (rstart[1-p] <= cyc - 2), 0);
               if (rwe[p]) ref_mem[raddr[p]] = rwd[p];
               else        last_rd[p] = ref_mem[raddr[p]];
               check($sformatf("rnd_p%0d_rdata", p), rd_s[p], last_rd[p]);
               $display("rnd cycle %0d: p%0d %s addr %02h rdata %02h", cyc, p,
                        rwe[p] ? "write" : "read", raddr[p], rd_s[p]);
               last_ack_port = p;
               rq[p] = 0;
            end else if (rq[p] && (cyc - rstart[p] > 12)) begin
               check($sformatf("rnd_p%0d_ack_timeout", p), rq[p], 0);
               rq[p] = 0;
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (!rq[p] && ($urandom_range(0, 9) < 4)) begin
               rq[p]     = 1;
               rwe[p]    = 1'($urandom_range(0, 1));
               raddr[p]  = 8'($urandom_range(0, 15));
               rwd[p]    = 8'($urandom);
               rstart[p] = cyc;
            end
         end
         p0_req = rq[0]; p0_we = rwe[0]; p0_addr = raddr[0]; p0_wdata = rwd[0];
         p1_req = rq[1]; p1_we = rwe[1]; p1_addr = raddr[1]; p1_wdata = rwd[1];
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
